// File: rtl/runner_pkg.sv
// Shared encodings for the runner game: FSM state codes and the speed-level ceiling.
package runner_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;
   localparam logic [1:0] ST_OVER   = 2'd3;

   localparam logic [1:0] MAX_LEVEL = 2'd2;

endpackage

// File: rtl/runner_tick_gen.sv
// Game tick divider: the period halves with each speed level, floored at MIN_DIV.
module runner_tick_gen
   import runner_pkg::*;
#(
   parameter int TICK_DIV = 250000,
   parameter int MIN_DIV  = 62500
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       run,
   input  logic       clear,
   input  logic [1:0] level,
   output logic       tick
);

   logic [31:0] cnt;
   logic [31:0] div_lvl;
   logic [31:0] period;

   always_comb begin
      div_lvl = 32'(TICK_DIV) >> level;
      period  = (div_lvl < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div_lvl;
      tick    = run && (cnt >= period - 32'd1);
   end

   // The count only moves while running, so a pause resumes mid-period.
   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= tick ? '0 : cnt + 32'd1;
      end
   end

endmodule

// File: rtl/runner_game_core.sv
// Endless-runner game core: FSM, scrolling obstacle row, jump timer, score and speed level.
module runner_game_core
   import runner_pkg::*;
#(
   parameter int COLS       = 16,
   parameter int TICK_DIV   = 250000,
   parameter int MIN_DIV    = 62500,
   parameter int JUMP_TICKS = 3,
   parameter int MIN_GAP    = 3,
   parameter int LEVEL_STEP = 20
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            start,
   input  logic            jump,
   input  logic            pause,
   input  logic            abort,
   input  logic [15:0]     rand_in,
   output logic [1:0]      state,
   output logic            airborne,
   output logic [COLS-1:0] obstacle_map,
   output logic [31:0]     score,
   output logic [1:0]      level,
   output logic            frame_update
);

   localparam int            JW        = (JUMP_TICKS < 1) ? 1 : $clog2(JUMP_TICKS + 1);
   localparam logic [JW-1:0] JUMP_LOAD = JW'(JUMP_TICKS);

   logic [JW-1:0]   jump_cnt;
   logic [JW-1:0]   jump_cnt_nxt;
   logic [1:0]      state_nxt;
   logic            tick;
   logic            run;
   logic            start_ok;
   logic            tick_run;
   logic            jump_ok;
   logic            spawn;
   logic            collide;
   logic            air_nxt;
   logic [COLS-1:0] map_shift;
   logic [31:0]     score_inc;
   logic            rand_unused;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [1:0] level_bump(input logic [1:0] lv, input logic [31:0] new_score);
      if ((new_score != 0) && ((new_score % 32'(LEVEL_STEP)) == 0) && (lv < MAX_LEVEL))
         return lv + 2'd1;
      return lv;
   endfunction

   assign run         = (state == ST_RUN);
   assign start_ok    = start && ((state == ST_IDLE) || (state == ST_OVER));
   assign tick_run    = tick && run && !abort;
   assign rand_unused = ^rand_in[15:3];

   runner_tick_gen #(
      .TICK_DIV (TICK_DIV),
      .MIN_DIV  (MIN_DIV)
   ) u_tick (
      .CLK   (CLK),
      .RST   (RST),
      .run   (run),
      .clear (start_ok),
      .level (level),
      .tick  (tick)
   );

   always_comb begin
      map_shift           = {1'b0, obstacle_map[COLS-1:1]};
      spawn               = (rand_in[2:0] == 3'd0) && (obstacle_map[COLS-1 -: MIN_GAP] == '0);
      map_shift[COLS-1]   = spawn;

      // A jump landing on the tick cycle takes effect before the collision test.
      jump_ok      = run && jump && !airborne && !abort && !pause;
      air_nxt      = airborne;
      jump_cnt_nxt = jump_cnt;
      if (jump_ok) begin
         air_nxt      = 1'b1;
         jump_cnt_nxt = JUMP_LOAD;
      end else if (tick_run && (jump_cnt != '0)) begin
         jump_cnt_nxt = jump_cnt - JW'(1);
         if (jump_cnt_nxt == '0)
            air_nxt = 1'b0;
      end

      collide   = tick_run && map_shift[0] && !air_nxt;
      score_inc = sat_inc(score);

      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_RUN;
         ST_RUN: begin
            if (abort || collide) state_nxt = ST_OVER;
            else if (pause)       state_nxt = ST_PAUSED;
         end
         ST_PAUSED: begin
            if (abort)      state_nxt = ST_OVER;
            else if (pause) state_nxt = ST_RUN;
         end
         ST_OVER:   if (start) state_nxt = ST_RUN;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= ST_IDLE;
         airborne     <= 1'b0;
         jump_cnt     <= '0;
         obstacle_map <= '0;
         score        <= '0;
         level        <= '0;
         frame_update <= 1'b0;
      end else begin
         state        <= state_nxt;
         frame_update <= tick_run || (state_nxt != state);
         if (start_ok) begin
            airborne     <= 1'b0;
            jump_cnt     <= '0;
            obstacle_map <= '0;
            score        <= '0;
            level        <= '0;
         end else if (run && !abort) begin
            airborne <= air_nxt;
            jump_cnt <= jump_cnt_nxt;
            // The row still scrolls on the fatal tick; only the score is withheld.
            if (tick_run) begin
               obstacle_map <= map_shift;
               if (!collide) begin
                  score <= score_inc;
                  level <= level_bump(level, score_inc);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_runner_game_core.sv
// Directed bench for runner_game_core with a queue of expected per-frame snapshots.
module tb_runner_game_core;

   localparam int COLS = 8;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            start = 1'b0;
   logic            jump = 1'b0;
   logic            pause = 1'b0;
   logic            abort = 1'b0;
   logic [15:0]     rand_in = 16'h0000;
   logic [1:0]      state;
   logic            airborne;
   logic [COLS-1:0] obstacle_map;
   logic [31:0]     score;
   logic [1:0]      level;
   logic            frame_update;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0]  st;
      logic [31:0] sc;
      logic [7:0]  mp;
      logic        air;
      logic [1:0]  lv;
   } exp_t;

   exp_t sb_q[$];

   logic [7:0] a_map [8];
   logic [1:0] a_lvl [8];

   runner_game_core #(
      .COLS       (COLS),
      .TICK_DIV   (8),
      .MIN_DIV    (2),
      .JUMP_TICKS (2),
      .MIN_GAP    (2),
      .LEVEL_STEP (4)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start),
      .jump         (jump),
      .pause        (pause),
      .abort        (abort),
      .rand_in      (rand_in),
      .state        (state),
      .airborne     (airborne),
      .obstacle_map (obstacle_map),
      .score        (score),
      .level        (level),
      .frame_update (frame_update)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick_clk();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] st, input logic [31:0] sc, input logic [7:0] mp,
                           input logic air, input logic [1:0] lv);
      exp_t e;
      e.st = st; e.sc = sc; e.mp = mp; e.air = air; e.lv = lv;
      sb_q.push_back(e);
   endtask

   task automatic wait_frame(input string tag, output int ncyc);
      exp_t e;
      bit   got;
      got  = 1'b0;
      ncyc = 0;
      while (!got && ncyc < 100) begin
         tick_clk();
         ncyc++;
         got = (frame_update === 1'b1);
      end
      chk($sformatf("%s_frame", tag), 32'(got), 32'd1);
      e = sb_q.pop_front();
      chk($sformatf("%s_state", tag), 32'(state), 32'(e.st));
      chk($sformatf("%s_score", tag), score, e.sc);
      chk($sformatf("%s_map", tag), 32'(obstacle_map), 32'(e.mp));
      chk($sformatf("%s_air", tag), 32'(airborne), 32'(e.air));
      chk($sformatf("%s_level", tag), 32'(level), 32'(e.lv));
   endtask

   initial begin
      int n;
      int fc;
      a_map = '{8'h80, 8'h40, 8'h20, 8'h90, 8'h48, 8'h24, 8'h92, 8'h49};
      a_lvl = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};

      // Reset and idle behaviour
      repeat (2) tick_clk();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_air", 32'(airborne), 32'd0);
      chk("rst_map", 32'(obstacle_map), 32'd0);
      chk("rst_score", score, 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_frame", 32'(frame_update), 32'd0);
      RST = 1'b0;
      pause = 1'b1; abort = 1'b1; jump = 1'b1;
      tick_clk();
      pause = 1'b0; abort = 1'b0; jump = 1'b0;
      chk("idle_ign_state", 32'(state), 32'd0);
      chk("idle_ign_frame", 32'(frame_update), 32'd0);
      chk("idle_ign_air", 32'(airborne), 32'd0);

      // Scenario A: no jump, collision on tick 8
      rand_in = 16'h0000;
      start = 1'b1; tick_clk(); start = 1'b0;
      chk("a_start_state", 32'(state), 32'd1);
      chk("a_start_frame", 32'(frame_update), 32'd1);
      for (int i = 0; i < 8; i++) begin
         push_exp((i == 7) ? 2'd3 : 2'd1, (i == 7) ? 32'd7 : 32'(i + 1), a_map[i], 1'b0, a_lvl[i]);
         wait_frame($sformatf("a_t%0d", i + 1), n);
         if (i == 0) chk("a_period_l0", 32'(n), 32'd8);
         if (i == 4) chk("a_period_l1", 32'(n), 32'd4);
      end
      fc = 0;
      repeat (20) begin
         tick_clk();
         if (frame_update === 1'b1) fc++;
      end
      jump = 1'b1; tick_clk(); jump = 1'b0;
      chk("over_hold_state", 32'(state), 32'd3);
      chk("over_hold_score", score, 32'd7);
      chk("over_hold_map", 32'(obstacle_map), 32'h49);
      chk("over_hold_frames", 32'(fc), 32'd0);
      chk("over_jump_ign", 32'(airborne), 32'd0);

      // Scenario B: jump one cycle before tick 8 avoids the collision
      start = 1'b1; tick_clk(); start = 1'b0;
      chk("b_start_state", 32'(state), 32'd1);
      chk("b_start_map", 32'(obstacle_map), 32'd0);
      chk("b_start_score", score, 32'd0);
      chk("b_start_level", 32'(level), 32'd0);
      for (int i = 0; i < 7; i++) begin
         push_exp(2'd1, 32'(i + 1), a_map[i], 1'b0, a_lvl[i]);
         wait_frame($sformatf("b_t%0d", i + 1), n);
      end
      repeat (2) tick_clk();
      jump = 1'b1; tick_clk(); jump = 1'b0;
      chk("b_jump_air", 32'(airborne), 32'd1);
      chk("b_jump_score", score, 32'd7);
      push_exp(2'd1, 32'd8, 8'h49, 1'b1, 2'd2);
      wait_frame("b_t8", n);
      chk("b_t8_delay", 32'(n), 32'd1);
      push_exp(2'd1, 32'd9, 8'h24, 1'b0, 2'd2);
      wait_frame("b_t9", n);
      chk("b_period_l2", 32'(n), 32'd2);
      abort = 1'b1; tick_clk(); abort = 1'b0;
      chk("b_abort_state", 32'(state), 32'd3);

      // Scenario C: pause mid-period, start ignored in RUN, jump ignored while airborne
      rand_in = 16'h0001;
      start = 1'b1; tick_clk(); start = 1'b0;
      repeat (2) tick_clk();
      pause = 1'b1; tick_clk(); pause = 1'b0;
      chk("c_pause_state", 32'(state), 32'd2);
      chk("c_pause_frame", 32'(frame_update), 32'd1);
      repeat (50) tick_clk();
      chk("c_held_state", 32'(state), 32'd2);
      chk("c_held_score", score, 32'd0);
      pause = 1'b1; tick_clk(); pause = 1'b0;
      chk("c_resume_state", 32'(state), 32'd1);
      push_exp(2'd1, 32'd1, 8'h00, 1'b0, 2'd0);
      wait_frame("c_t1", n);
      chk("c_resume_delay", 32'(n), 32'd5);
      start = 1'b1; tick_clk(); start = 1'b0;
      chk("c_start_ign_state", 32'(state), 32'd1);
      chk("c_start_ign_score", score, 32'd1);
      jump = 1'b1; tick_clk(); jump = 1'b0;
      chk("c_jump_air", 32'(airborne), 32'd1);
      repeat (2) tick_clk();
      jump = 1'b1; tick_clk(); jump = 1'b0;
      push_exp(2'd1, 32'd2, 8'h00, 1'b1, 2'd0);
      wait_frame("c_t2", n);
      chk("c_t2_delay", 32'(n), 32'd3);
      push_exp(2'd1, 32'd3, 8'h00, 1'b0, 2'd0);
      wait_frame("c_t3", n);
      abort = 1'b1; tick_clk(); abort = 1'b0;

      // Scenario D: level progression and tick periods
      start = 1'b1; tick_clk(); start = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         push_exp(2'd1, 32'(i), 8'h00, 1'b0, (i >= 8) ? 2'd2 : ((i >= 4) ? 2'd1 : 2'd0));
         wait_frame($sformatf("d_t%0d", i), n);
         chk($sformatf("d_t%0d_period", i), 32'(n), (i <= 4) ? 32'd8 : ((i <= 8) ? 32'd4 : 32'd2));
      end

      // Scenario E: abort beats pause, single frame pulse
      abort = 1'b1; pause = 1'b1; tick_clk(); abort = 1'b0; pause = 1'b0;
      chk("e_state", 32'(state), 32'd3);
      fc = (frame_update === 1'b1) ? 1 : 0;
      repeat (10) begin
         tick_clk();
         if (frame_update === 1'b1) fc++;
      end
      chk("e_frames", 32'(fc), 32'd1);
      chk("e_state_hold", 32'(state), 32'd3);

      // Scenario F: reset mid-jump
      start = 1'b1; tick_clk(); start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         push_exp(2'd1, 32'(i), 8'h00, 1'b0, (i == 4) ? 2'd1 : 2'd0);
         wait_frame($sformatf("f_t%0d", i), n);
      end
      jump = 1'b1; tick_clk(); jump = 1'b0;
      push_exp(2'd1, 32'd5, 8'h00, 1'b1, 2'd1);
      wait_frame("f_t5", n);
      RST = 1'b1; jump = 1'b1; start = 1'b1; tick_clk();
      RST = 1'b0; jump = 1'b0; start = 1'b0;
      chk("f_rst_state", 32'(state), 32'd0);
      chk("f_rst_air", 32'(airborne), 32'd0);
      chk("f_rst_map", 32'(obstacle_map), 32'd0);
      chk("f_rst_score", score, 32'd0);
      chk("f_rst_level", 32'(level), 32'd0);
      chk("f_rst_frame", 32'(frame_update), 32'd0);
      start = 1'b1; tick_clk(); start = 1'b0;
      push_exp(2'd1, 32'd1, 8'h00, 1'b0, 2'd0);
      wait_frame("f_restart_t1", n);
      chk("f_restart_period", 32'(n), 32'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/runner_game_core.md
RUNNER_GAME_CORE -- requirements
Module: runner_game_core

Interface
REQ-001 The block SHALL have parameter COLS, default 16, giving the playfield width in columns (4..32).
REQ-002 The block SHALL have parameter TICK_DIV, default 250000, giving base CLK cycles per game tick at level 0.
REQ-003 The block SHALL have parameter MIN_DIV, default 62500, giving the floor on the tick period.
REQ-004 The block SHALL have parameter JUMP_TICKS, default 3, giving the number of ticks the dino stays airborne.
REQ-005 The block SHALL have parameter MIN_GAP, default 3, giving the minimum number of empty columns between spawned obstacles.
REQ-006 The block SHALL have parameter LEVEL_STEP, default 20, giving the score points per speed level; MAX_LEVEL is fixed at 2 and is not a parameter.
REQ-007 The block SHALL have one clock; reset is synchronous and active-high.
REQ-008 CLK  in  1  system clock, all logic on rising edge.
REQ-009 RST  in  1  synchronous active-high reset.
REQ-010 start  in  1  one-cycle pulse; begins a new game.
REQ-011 jump  in  1  one-cycle pulse; jump request.
REQ-012 pause  in  1  one-cycle pulse; toggles pause.
REQ-013 abort  in  1  one-cycle pulse; forces game over.
REQ-014 rand_in  in  16  free-running pseudo-random value.
REQ-015 state  out  2  IDLE=0, RUN=1, PAUSED=2, OVER=3.
REQ-016 airborne  out  1  dino is in the upper row.
REQ-017 obstacle_map  out  COLS  bit i set = obstacle in column i; column 0 is the dino column.
REQ-018 score  out  32  ticks survived in the current game.
REQ-019 level  out  2  current speed level, 0..MAX_LEVEL.
REQ-020 frame_update  out  1  one-cycle pulse requesting a display refresh.

Function
REQ-021 The FSM SHALL transition IDLE->RUN on start, RUN<->PAUSED on pause, RUN/PAUSED->OVER on abort or collision, and OVER->RUN on start; all other inputs in a state SHALL be ignored.
REQ-022 Entry to RUN via start SHALL, in the same edge, clear obstacle_map, score, level, airborne, the jump counter and the tick counter.
REQ-023 In RUN the tick counter SHALL count to period-1 and then emit a one-cycle tick, with period = max(TICK_DIV >> level, MIN_DIV).
REQ-024 In PAUSED, IDLE and OVER the tick counter SHALL hold its value, and resuming from PAUSED SHALL continue from the held count.
REQ-025 On a tick, obstacle_map SHALL shift toward column 0 (map[i] <= map[i+1]) and the bit shifted out of column 0 SHALL be discarded.
REQ-026 On a tick, map[COLS-1] SHALL be set iff rand_in[2:0]==0 and the top MIN_GAP columns of the pre-shift map are all zero.
REQ-027 A jump pulse in RUN with airborne=0 SHALL set airborne=1 and load the jump counter with JUMP_TICKS on the next edge.
REQ-028 A jump pulse while airborne or outside RUN SHALL be ignored.
REQ-029 Each tick SHALL decrement the jump counter, and airborne SHALL clear on the tick at which the counter reaches 0.
REQ-030 A collision SHALL occur when the post-shift map[0]=1 and airborne=0 after the tick update, and it SHALL move the FSM to OVER on that edge with score not incremented.
REQ-031 A jump and a tick in the same cycle SHALL apply the jump first, so no collision occurs.
REQ-032 Each collision-free tick SHALL increment score, saturating at 32'hFFFF_FFFF.
REQ-033 level SHALL increment when the new score is a nonzero multiple of LEVEL_STEP, saturating at MAX_LEVEL.
REQ-034 When inputs coincide in a cycle, priority SHALL be abort > collision > pause > jump.
REQ-035 A start pulse in RUN or PAUSED SHALL be ignored.
REQ-036 In OVER, obstacle_map, score and level SHALL hold their final values.
REQ-037 frame_update SHALL pulse for one cycle on the edge after any tick in RUN and on the edge after any state change.
REQ-038 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-039 Reset SHALL set state=IDLE and clear airborne, obstacle_map, score, level, frame_update, the tick counter and the jump counter.
REQ-040 Reset SHALL take precedence over every input, including mid-game and mid-jump.

Structure
REQ-041 The state encodings and the MAX_LEVEL constant SHALL live in the shared package runner_pkg.
REQ-042 The tick divider SHALL be the sub-module runner_tick_gen, with inputs CLK, RST, run, clear and level, and output tick.
REQ-043 The shift register, jump counter and FSM SHALL live in runner_game_core.

Verification
REQ-044 Bench parameters SHALL be COLS=8, TICK_DIV=8, MIN_DIV=2, JUMP_TICKS=2, MIN_GAP=2 and LEVEL_STEP=4.
REQ-045 Scenario: rand_in=0 constantly, start, no jump -> map[7] set on tick 1, collision on tick 8, state=3 and score=7.
REQ-046 Scenario: jump issued one cycle before tick 8 -> airborne=1 over ticks 8-9, no collision, score=8 after tick 8.
REQ-047 Scenario: pause at cycle 3 of a tick period, held 50 cycles, pause again -> next tick arrives exactly 5 cycles after resume.
REQ-048 Scenario: rand_in=16'h0001 constantly -> map stays 0 and score reaches 4, 8, 12 with periods 8, 4, 2 and level 1, 2, 2.
REQ-049 Scenario: abort and pause in the same cycle in RUN -> state=3 and frame_update pulses once.
REQ-050 Scenario: RST asserted mid-jump with score=5 -> on the next edge all outputs are zero and state=0.
